// File: rtl/alu_seq_multiplier.sv
// Unsigned W x W -> 2W shift-add multiplier that borrows an external ALU
// for its only adder. The ALU is driven combinationally from registers in
// RUN, and its sum plus carry is folded back into {acc,q} at the next edge.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; ALU operands parked at zero
// RUN   | one add-and-shift per cycle, WIDTH cycles, start ignored
// DONE  | one-cycle done pulse; a start here launches the next multiply
module alu_seq_multiplier #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SEL_WIDTH = 4,
  parameter int unsigned ADD_SEL   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       multiplicand,
  input  logic [WIDTH-1:0]       multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [WIDTH-1:0]       alu_input0,
  output logic [WIDTH-1:0]       alu_input1,
  output logic [SEL_WIDTH-1:0]   alu_select,
  input  logic [WIDTH-1:0]       alu_outputf,
  input  logic                   alu_carryout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Carry, sum and the low half form one (2W+1)-bit word; dropping its LSB
  // is the per-step right shift, so the carry lands in the top bit of acc.
  logic [2*WIDTH:0]     step_cat;
  logic [2*WIDTH-1:0]   step_shifted;

  assign step_cat     = {alu_carryout, alu_outputf, q_q};
  assign step_shifted = step_cat[2*WIDTH:1];

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign product    = product_q;
  assign alu_select = SEL_WIDTH'(ADD_SEL);

  // ALU operands are only live in RUN; elsewhere they are held at zero.
  always_comb begin
    alu_input0 = '0;
    alu_input1 = '0;
    if (state_q == RUN) begin
      alu_input0 = acc_q;
      alu_input1 = q_q[0] ? m_q : '0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        {acc_d, q_d} = step_shifted;
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          product_d = step_shifted;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for alu_seq_multiplier with a behavioural ALU model.
// Expected products are pushed when a start is issued; a monitor pops and
// compares them whenever done is seen.
module tb_alu_seq_multiplier;

  localparam int W  = 8;
  localparam int SW = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   alu_input0;
  logic [W-1:0]   alu_input1;
  logic [SW-1:0]  alu_select;
  logic [W-1:0]   alu_outputf;
  logic           alu_carryout;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_done = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] prev_prod;

  alu_seq_multiplier #(.WIDTH(W), .SEL_WIDTH(SW), .ADD_SEL(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_input0   (alu_input0),
    .alu_input1   (alu_input1),
    .alu_select   (alu_select),
    .alu_outputf  (alu_outputf),
    .alu_carryout (alu_carryout)
  );

  // External ALU: add with carry on select 0, a deliberately different
  // result on any other code so a wrong select cannot go unnoticed.
  always_comb begin
    if (alu_select == '0) {alu_carryout, alu_outputf} = {1'b0, alu_input0} + {1'b0, alu_input1};
    else                  {alu_carryout, alu_outputf} = {1'b0, alu_input0 ^ alu_input1};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) check("unexpected_done", 32'(product), 32'hFFFF_FFFF);
      else check("product", 32'(product), 32'(exp_q.pop_front()));
    end
  end

  // Drive a start just before the next edge; the edge that samples it is E.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input bit push);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    if (push) begin
      exp_q.push_back(exp);
      n_push++;
    end
    @(posedge clk);
    #1 start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
  endtask

  // Walk the W RUN cycles after edge E; optionally poke start mid-run.
  task automatic wait_run(input int poke_at);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      check("select_run", 32'(alu_select), 32'd0);
      if (k == 0) check("product_held", 32'(product), 32'(prev_prod));
      if (k == poke_at) begin
        start = 1'b1;
        multiplicand = 8'd1;
        multiplier = 8'd1;
      end
      if (k == poke_at + 1) begin
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
      end
    end
  endtask

  task automatic expect_done(input logic [2*W-1:0] exp);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("alu_in0_idle", 32'(alu_input0), 32'd0);
    prev_prod = exp;
  endtask

  task automatic expect_idle();
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    issue(a, b, exp, 1'b1);
    wait_run(-1);
    expect_done(exp);
    expect_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    prev_prod = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_alu_in0", 32'(alu_input0), 32'd0);
    check("rst_alu_in1", 32'(alu_input1), 32'd0);
    check("rst_select", 32'(alu_select), 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);

    op(8'd13,  8'd11,  16'h008F);
    op(8'd255, 8'd255, 16'hFE01);
    op(8'd0,   8'd200, 16'h0000);
    op(8'd200, 8'd0,   16'h0000);

    // Start during RUN cycle 3 must be ignored.
    issue(8'd7, 8'd9, 16'h003F, 1'b1);
    wait_run(3);
    expect_done(16'h003F);
    expect_idle();

    // Back-to-back: start sampled on the DONE cycle.
    issue(8'd5, 8'd5, 16'd25, 1'b1);
    wait_run(-1);
    expect_done(16'd25);
    issue(8'd2, 8'd3, 16'd6, 1'b1);
    wait_run(-1);
    expect_done(16'd6);
    expect_idle();

    // Asynchronous reset in the middle of RUN discards the operation.
    issue(8'd255, 8'd255, 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_product", 32'(product), 32'd0);
    check("arst_alu_in0", 32'(alu_input0), 32'd0);
    check("arst_alu_in1", 32'(alu_input1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_prod = '0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    op(8'd3, 8'd4, 16'd12);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_push));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
